// File: rtl/stopwatch_display.sv
// Eight-digit HH:MM:SS.hh stopwatch: BCD time base with cascaded rollover,
// run/pause/clear/lap control, and a multiplexed common-anode 7-segment driver.
module stopwatch_display #(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned TICK_HZ       = 100,
  parameter int unsigned SCAN_HZ       = 1000,
  parameter logic [7:0]  DP_MASK       = 8'b01010100,
  parameter bit          LEADING_BLANK = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [7:0]  cathode,
  output logic [7:0]  anode,
  output logic [31:0] time_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  // Per-nibble terminal value; also the full-scale 99:59:59.99 pattern.
  localparam logic [31:0] BCD_MAX = 32'h9959_5999;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   time_q, time_d;
  logic [31:0]   snap_q, snap_d;
  logic          lap_q, lap_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   time_inc;
  logic          wrap;

  always_comb begin : bcd_increment
    logic carry;
    carry    = 1'b1;
    time_inc = time_q;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        if (time_q[4*i +: 4] >= BCD_MAX[4*i +: 4]) begin
          time_inc[4*i +: 4] = 4'd0;
        end else begin
          time_inc[4*i +: 4] = time_q[4*i +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  // Tick is evaluated from the current state, so a start_stop coinciding
  // with a tick still counts it before the state changes.
  always_comb begin : control_next
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    presc_d = presc_q;
    time_d  = time_q;
    snap_d  = snap_q;
    lap_d   = lap_q;
    ovf_d   = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
      time_d  = '0;
      snap_d  = '0;
      lap_d   = 1'b0;
    end else begin
      if (state_q == ST_RUN) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          time_d  = time_inc;
          ovf_d   = wrap;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      if (start_stop) begin
        state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
      end else if (lap) begin
        if (lap_q) begin
          lap_d = 1'b0;
        end else if (state_q == ST_RUN) begin
          lap_d  = 1'b1;
          snap_d = time_q;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of process order.
      state_q <= ST_IDLE;
      presc_q <= '0;
      time_q  <= '0;
      snap_q  <= '0;
      lap_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      time_q  <= time_d;
      snap_q  <= snap_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign time_bcd   = time_q;
  assign running    = (state_q == ST_RUN);
  assign lap_active = lap_q;
  assign overflow   = ovf_q;

  logic [SW-1:0] sdiv_q;
  logic [2:0]    idx_q;
  logic [7:0]    cathode_q, anode_q;
  logic [31:0]   disp;
  logic [3:0]    nib;
  logic [6:0]    seg;

  assign disp = lap_q ? snap_q : time_q;
  assign nib  = disp[4*idx_q +: 4];

  always_comb begin : seg_decode
    unique case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'h7F;
    endcase
    if (LEADING_BLANK && (idx_q == 3'd7) && (nib == 4'd0)) begin
      seg = 7'h7F;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sdiv_q    <= '0;
      idx_q     <= '0;
      cathode_q <= 8'hFF;
      anode_q   <= 8'hFF;
    end else begin
      if (sdiv_q == SCAN_LAST) begin
        sdiv_q <= '0;
        idx_q  <= idx_q + 3'd1;
      end else begin
        sdiv_q <= sdiv_q + 1'b1;
      end
      cathode_q <= {~DP_MASK[idx_q], seg};
      anode_q   <= ~(8'b1 << idx_q);
    end
  end

  assign cathode = cathode_q;
  assign anode   = anode_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display: directed scenarios plus random
// pulses, all compared against a hundredths-count reference model.
module tb_stopwatch_display;

  localparam int TICK_DIV = 10;
  localparam int SCAN_DIV = 2;
  localparam logic [7:0] DP_MASK = 8'b01010100;
  localparam int MAX_HUND = 99*360000 + 59*6000 + 59*100 + 99;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic [7:0]  cathode, anode;
  logic [31:0] time_bcd;
  logic        running, lap_active, overflow;

  stopwatch_display #(
    .CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(500),
    .DP_MASK(8'b01010100), .LEADING_BLANK(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start_stop(start_stop), .clear(clear),
    .lap(lap), .cathode(cathode), .anode(anode), .time_bcd(time_bcd),
    .running(running), .lap_active(lap_active), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: time kept as a plain count of hundredths.
  int         m_state, m_presc, m_hund, m_snap, m_idx, m_sdiv;
  bit         m_lap, m_ovf;
  logic [7:0] m_anode, m_cathode;

  function automatic logic [31:0] to_bcd(input int hund);
    int hs, s, m, hh;
    hs = hund % 100;
    s  = (hund / 100) % 60;
    m  = (hund / 6000) % 60;
    hh = (hund / 360000) % 100;
    return {4'(hh / 10), 4'(hh % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(hs / 10), 4'(hs % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_presc = 0; m_hund = 0; m_snap = 0;
    m_idx = 0; m_sdiv = 0; m_lap = 0; m_ovf = 0;
    m_anode = 8'hFF; m_cathode = 8'hFF;
  endtask

  task automatic model_edge(input logic ss, input logic clr, input logic lp);
    logic [31:0] disp;
    logic [3:0]  nb;
    logic [6:0]  sg;
    int          old_hund, old_state;
    disp = to_bcd(m_lap ? m_snap : m_hund);
    nb   = disp[4*m_idx +: 4];
    sg   = (m_idx == 7 && nb == 4'd0) ? 7'h7F : seg_of(nb);
    m_anode   = ~(8'b1 << m_idx);
    m_cathode = {~DP_MASK[m_idx], sg};
    if (m_sdiv == SCAN_DIV - 1) begin
      m_sdiv = 0;
      m_idx  = (m_idx + 1) % 8;
    end else begin
      m_sdiv++;
    end
    m_ovf     = 0;
    old_hund  = m_hund;
    old_state = m_state;
    if (clr) begin
      m_state = M_IDLE; m_presc = 0; m_hund = 0; m_lap = 0; m_snap = 0;
    end else begin
      if (old_state == M_RUN) begin
        if (m_presc == TICK_DIV - 1) begin
          m_presc = 0;
          m_hund++;
          if (m_hund > MAX_HUND) begin
            m_hund = 0;
            m_ovf  = 1;
          end
        end else begin
          m_presc++;
        end
      end
      if (ss) begin
        m_state = (old_state == M_RUN) ? M_PAUSE : M_RUN;
      end else if (lp) begin
        if (m_lap) m_lap = 0;
        else if (old_state == M_RUN) begin
          m_lap  = 1;
          m_snap = old_hund;
        end
      end
    end
  endtask

  // Drive pulses for one cycle, advance the model on the edge, and return
  // on the following falling edge where outputs are sampled.
  task automatic step(input logic ss, input logic clr, input logic lp);
    start_stop = ss; clear = clr; lap = lp;
    @(posedge clock);
    model_edge(ss, clr, lp);
    @(negedge clock);
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic test_reset();
    int d;
    logic [7:0] ea, ec;
    model_reset();
    repeat (3) @(negedge clock);
    n_vec++;
    if (anode !== 8'hFF || cathode !== 8'hFF) begin
      n_miss++;
      $display("FAIL reset_pins: anode=%h cathode=%h expected FF/FF", anode, cathode);
    end
    n_vec++;
    if (time_bcd !== 32'h0 || running !== 1'b0 || lap_active !== 1'b0 || overflow !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_status: time=%h run=%b lap=%b ovf=%b expected 0", time_bcd,
               running, lap_active, overflow);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(0, 0, 0);
      d  = (k - 1) / 2;
      ea = ~(8'b1 << d);
      ec = (d == 7) ? 8'hFF : ((d == 2 || d == 4 || d == 6) ? 8'h40 : 8'hC0);
      n_vec++;
      if (anode !== ea || cathode !== ec) begin
        n_miss++;
        $display("FAIL scan_walk[%0d]: anode=%h cathode=%h expected %h/%h", k, anode, cathode,
                 ea, ec);
      end
    end
  endtask

  task automatic test_run_pause();
    int steps;
    step(1, 0, 0);
    n_vec++;
    if (running !== 1'b1) begin
      n_miss++;
      $display("FAIL start_running: got %b expected 1", running);
    end
    repeat (1000) step(0, 0, 0);
    n_vec++;
    if (time_bcd !== 32'h0000_0100) begin
      n_miss++;
      $display("FAIL run_100_ticks: got %h expected 00000100", time_bcd);
    end
    step(1, 0, 0);
    repeat (500) step(0, 0, 0);
    n_vec++;
    if (time_bcd !== 32'h0000_0100 || running !== 1'b0) begin
      n_miss++;
      $display("FAIL pause_hold: time=%h run=%b expected 00000100/0", time_bcd, running);
    end
    step(1, 0, 0);
    steps = 0;
    while (time_bcd === 32'h0000_0100 && steps < 3 * TICK_DIV) begin
      step(0, 0, 0);
      steps++;
    end
    // The pause edge itself advanced the prescaler once, leaving TICK_DIV-1.
    n_vec++;
    if (steps != TICK_DIV - 1 || time_bcd !== 32'h0000_0101) begin
      n_miss++;
      $display("FAIL resume_remaining: %0d cycles time=%h expected %0d cycles 00000101", steps,
               time_bcd, TICK_DIV - 1);
    end
  endtask

  task automatic test_cascade();
    int pulses;
    step(0, 1, 0);
    step(1, 0, 0);
    repeat (5999 * TICK_DIV) step(0, 0, 0);
    n_vec++;
    if (time_bcd !== 32'h0000_5999) begin
      n_miss++;
      $display("FAIL cascade_pre: got %h expected 00005999", time_bcd);
    end
    repeat (TICK_DIV) step(0, 0, 0);
    n_vec++;
    if (time_bcd !== 32'h0001_0000 || time_bcd !== to_bcd(m_hund)) begin
      n_miss++;
      $display("FAIL cascade_minute: got %h expected 00010000", time_bcd);
    end
    step(1, 0, 0);
    force dut.time_q = 32'h9959_5999;
    step(0, 0, 0);
    release dut.time_q;
    m_hund = MAX_HUND;
    n_vec++;
    if (time_bcd !== 32'h9959_5999) begin
      n_miss++;
      $display("FAIL preload_full: got %h expected 99595999", time_bcd);
    end
    step(1, 0, 0);
    pulses = 0;
    for (int k = 0; k < 2 * TICK_DIV; k++) begin
      step(0, 0, 0);
      if (overflow === 1'b1) pulses++;
      n_vec++;
      if (overflow !== m_ovf || time_bcd !== to_bcd(m_hund)) begin
        n_miss++;
        $display("FAIL wrap[%0d]: ovf=%b time=%h expected %b %h", k, overflow, time_bcd, m_ovf,
                 to_bcd(m_hund));
      end
    end
    n_vec++;
    if (pulses != 1) begin
      n_miss++;
      $display("FAIL overflow_count: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_lap();
    bit seen_digit2;
    step(0, 1, 0);
    step(1, 0, 0);
    repeat (1000) step(0, 0, 0);
    step(0, 0, 1);
    n_vec++;
    if (lap_active !== 1'b1) begin
      n_miss++;
      $display("FAIL lap_set: got %b expected 1", lap_active);
    end
    seen_digit2 = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 0, 0);
      if (anode === 8'hFB) begin
        seen_digit2 = 1;
        n_vec++;
        if (cathode !== 8'h79) begin
          n_miss++;
          $display("FAIL lap_frozen_digit2: got %h expected 79", cathode);
        end
      end
      n_vec++;
      if (cathode !== m_cathode || anode !== m_anode) begin
        n_miss++;
        $display("FAIL lap_display[%0d]: cathode=%h anode=%h expected %h %h", k, cathode, anode,
                 m_cathode, m_anode);
      end
    end
    n_vec++;
    if (!seen_digit2 || time_bcd !== 32'h0000_0104) begin
      n_miss++;
      $display("FAIL lap_live_count: time=%h seen=%0d expected 00000104 1", time_bcd, seen_digit2);
    end
    step(0, 0, 1);
    n_vec++;
    if (lap_active !== 1'b0) begin
      n_miss++;
      $display("FAIL lap_release: got %b expected 0", lap_active);
    end
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0);
      n_vec++;
      if (cathode !== m_cathode) begin
        n_miss++;
        $display("FAIL lap_tracks_live[%0d]: got %h expected %h", k, cathode, m_cathode);
      end
    end
  endtask

  task automatic test_simultaneous();
    step(0, 1, 0);
    step(1, 0, 0);
    repeat (37) step(0, 0, 0);
    step(1, 1, 0);
    n_vec++;
    if (time_bcd !== 32'h0 || running !== 1'b0 || lap_active !== 1'b0) begin
      n_miss++;
      $display("FAIL clear_beats_start: time=%h run=%b lap=%b expected 0/0/0", time_bcd,
               running, lap_active);
    end
  endtask

  task automatic test_random();
    logic ss, clr, lp;
    for (int k = 0; k < 3000; k++) begin
      ss  = ($urandom_range(0, 24) == 0);
      lp  = ($urandom_range(0, 11) == 0);
      clr = ($urandom_range(0, 299) == 0);
      step(ss, clr, lp);
      n_vec++;
      if (time_bcd !== to_bcd(m_hund) || overflow !== m_ovf) begin
        n_miss++;
        $display("FAIL rand_time[%0d]: time=%h ovf=%b expected %h %b", k, time_bcd, overflow,
                 to_bcd(m_hund), m_ovf);
      end
      n_vec++;
      if (running !== (m_state == M_RUN) || lap_active !== m_lap) begin
        n_miss++;
        $display("FAIL rand_ctrl[%0d]: run=%b lap=%b expected %b %b", k, running, lap_active,
                 (m_state == M_RUN), m_lap);
      end
      n_vec++;
      if (anode !== m_anode || cathode !== m_cathode) begin
        n_miss++;
        $display("FAIL rand_pins[%0d]: anode=%h cathode=%h expected %h %h", k, anode, cathode,
                 m_anode, m_cathode);
      end
    end
  endtask

  task automatic test_async_reset();
    step(0, 1, 0);
    step(1, 0, 0);
    repeat (25) step(0, 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (anode !== 8'hFF || cathode !== 8'hFF || time_bcd !== 32'h0 || running !== 1'b0 ||
        lap_active !== 1'b0 || overflow !== 1'b0) begin
      n_miss++;
      $display("FAIL async_reset: anode=%h cathode=%h time=%h run=%b lap=%b ovf=%b", anode,
               cathode, time_bcd, running, lap_active, overflow);
    end
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    step(0, 0, 0);
    n_vec++;
    if (anode !== 8'hFE || cathode !== 8'hC0) begin
      n_miss++;
      $display("FAIL post_reset_digit0: anode=%h cathode=%h expected FE C0", anode, cathode);
    end
  endtask

  initial begin
    test_reset();
    test_run_pause();
    test_cascade();
    test_lap();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
